// File: rtl/seg7_time_decoder_if.sv
// Bundle between the timer display path and the segment readback decoder:
// seven segment bytes plus start in, decode status and reconstructed time out.
interface seg7_time_decoder_if;
    logic        start;
    logic [7:0]  min_zehner;
    logic [7:0]  min_einer;
    logic [7:0]  sek_zehner;
    logic [7:0]  sek_einer;
    logic [7:0]  sek_zehntel;
    logic [7:0]  sek_hundertstel;
    logic [7:0]  sek_tausendstel;
    logic        busy;
    logic        done;
    logic        valid;
    logic        error;
    logic [1:0]  err_code;
    logic [2:0]  err_digit;
    logic        dp_fault;
    logic [27:0] digits;
    logic [31:0] ms_count;

    modport master (
        output start, min_zehner, min_einer, sek_zehner, sek_einer,
               sek_zehntel, sek_hundertstel, sek_tausendstel,
        input  busy, done, valid, error, err_code, err_digit, dp_fault,
               digits, ms_count
    );

    modport slave (
        input  start, min_zehner, min_einer, sek_zehner, sek_einer,
               sek_zehntel, sek_hundertstel, sek_tausendstel,
        output busy, done, valid, error, err_code, err_digit, dp_fault,
               digits, ms_count
    );
endinterface

// File: rtl/seg7_time_decoder.sv
// Snapshots seven segment bytes, decodes them one digit per cycle back to
// nibbles, range-checks them and rebuilds the elapsed time in milliseconds.
module seg7_time_decoder (
    input logic                 clk,
    input logic                 rst_n,
    seg7_time_decoder_if.slave  bus
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] DECODE = 2'd1;
    localparam logic [1:0] FINISH = 2'd2;

    localparam logic [1:0] CLS_DIGIT = 2'd0;
    localparam logic [1:0] CLS_HEX   = 2'd1;
    localparam logic [1:0] CLS_UNK   = 2'd2;

    // Returns {class, nibble}; unlit or garbled patterns map to nibble F.
    function automatic logic [5:0] decode_seg(input logic [6:0] pat);
        case (pat)
            7'b1111110: return {CLS_DIGIT, 4'h0};
            7'b0110000: return {CLS_DIGIT, 4'h1};
            7'b1101101: return {CLS_DIGIT, 4'h2};
            7'b1111001: return {CLS_DIGIT, 4'h3};
            7'b0110011: return {CLS_DIGIT, 4'h4};
            7'b1011011: return {CLS_DIGIT, 4'h5};
            7'b1011111: return {CLS_DIGIT, 4'h6};
            7'b1110000: return {CLS_DIGIT, 4'h7};
            7'b1111111: return {CLS_DIGIT, 4'h8};
            7'b1111011: return {CLS_DIGIT, 4'h9};
            7'b1110111: return {CLS_HEX,   4'hA};
            7'b0011111: return {CLS_HEX,   4'hB};
            7'b1001110: return {CLS_HEX,   4'hC};
            7'b0111101: return {CLS_HEX,   4'hD};
            7'b1001111: return {CLS_HEX,   4'hE};
            7'b1000111: return {CLS_HEX,   4'hF};
            default:    return {CLS_UNK,   4'hF};
        endcase
    endfunction

    function automatic logic [31:0] weight(input logic [2:0] i);
        case (i)
            3'd0:    return 32'd600000;
            3'd1:    return 32'd60000;
            3'd2:    return 32'd10000;
            3'd3:    return 32'd1000;
            3'd4:    return 32'd100;
            3'd5:    return 32'd10;
            default: return 32'd1;
        endcase
    endfunction

    logic [1:0]  state;
    logic [55:0] snap;
    logic [2:0]  idx;
    logic [31:0] acc;
    logic [27:0] dig_w;
    logic        err_w;
    logic [1:0]  code_w;
    logic [2:0]  edig_w;
    logic        dp_w;

    logic        busy_r, done_r, valid_r, error_r, dp_r;
    logic [1:0]  code_r;
    logic [2:0]  edig_r;
    logic [27:0] digits_r;
    logic [31:0] ms_r;

    logic [7:0]  cur;
    logic [5:0]  dec;
    logic [3:0]  nib;
    logic [1:0]  dcode;
    logic        dp_bad;

    // The snapshot shifts left each decode cycle, so the current digit is always on top.
    always_comb begin
        cur    = snap[55:48];
        dec    = decode_seg(cur[7:1]);
        nib    = dec[3:0];
        dcode  = 2'b00;
        if (dec[5:4] == CLS_UNK)
            dcode = 2'b01;
        else if (dec[5:4] == CLS_HEX)
            dcode = 2'b10;
        else if (idx == 3'd2 && nib > 4'd5)
            dcode = 2'b11;
        dp_bad = cur[0] != ((idx == 3'd1) || (idx == 3'd3));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            snap     <= '0;
            idx      <= '0;
            acc      <= '0;
            dig_w    <= '0;
            err_w    <= 1'b0;
            code_w   <= '0;
            edig_w   <= '0;
            dp_w     <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            valid_r  <= 1'b0;
            error_r  <= 1'b0;
            dp_r     <= 1'b0;
            code_r   <= '0;
            edig_r   <= '0;
            digits_r <= '0;
            ms_r     <= '0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        snap   <= {bus.min_zehner, bus.min_einer, bus.sek_zehner,
                                   bus.sek_einer, bus.sek_zehntel,
                                   bus.sek_hundertstel, bus.sek_tausendstel};
                        idx    <= '0;
                        acc    <= '0;
                        dig_w  <= '0;
                        err_w  <= 1'b0;
                        code_w <= '0;
                        edig_w <= '0;
                        dp_w   <= 1'b0;
                        busy_r <= 1'b1;
                        state  <= DECODE;
                    end
                end
                DECODE: begin
                    snap  <= {snap[47:0], 8'h00};
                    dig_w <= {dig_w[23:0], nib};
                    if (dcode == 2'b00)
                        acc <= acc + 32'(nib) * weight(idx);
                    if (!err_w && dcode != 2'b00) begin
                        err_w  <= 1'b1;
                        code_w <= dcode;
                        edig_w <= idx;
                    end
                    if (dp_bad)
                        dp_w <= 1'b1;
                    idx <= idx + 3'd1;
                    if (idx == 3'd6)
                        state <= FINISH;
                end
                FINISH: begin
                    digits_r <= dig_w;
                    error_r  <= err_w;
                    valid_r  <= !err_w;
                    code_r   <= code_w;
                    edig_r   <= edig_w;
                    dp_r     <= dp_w;
                    if (!err_w)
                        ms_r <= acc;
                    busy_r <= 1'b0;
                    done_r <= 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.valid     = valid_r;
    assign bus.error     = error_r;
    assign bus.err_code  = code_r;
    assign bus.err_digit = edig_r;
    assign bus.dp_fault  = dp_r;
    assign bus.digits    = digits_r;
    assign bus.ms_count  = ms_r;
endmodule

// File: tb/tb_seg7_time_decoder.sv
// Bench for seg7_time_decoder: fixed vector table, mid-decode reset, and
// randomized segment bytes checked against an arithmetic reference model.
module tb_seg7_time_decoder;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    seg7_time_decoder_if bus();

    seg7_time_decoder dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic [27:0] digits;
        logic [31:0] ms;
        logic        valid;
        logic        err;
        logic [1:0]  code;
        logic [2:0]  edig;
        logic        dp;
    } res_t;

    typedef struct {
        logic [55:0] bytes;
        bit          pulse;
        res_t        exp;
    } vec_t;

    int total = 0;
    int bad   = 0;
    logic [31:0] prev_ms = '0;
    logic [6:0]  pats [16] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                               7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                               7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
                               7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, req);
        end
    endtask

    function automatic res_t model(input logic [55:0] b, input logic [31:0] prev);
        res_t r;
        int   d [7];
        r = '0;
        for (int i = 0; i < 7; i++) begin
            logic [7:0] by;
            int   nib;
            bit   found;
            logic [1:0] code;
            by = b[55 - 8*i -: 8];
            nib = 15;
            found = 0;
            for (int k = 0; k < 16; k++)
                if (pats[k] == by[7:1]) begin nib = k; found = 1; end
            code = 2'b00;
            if (!found)                code = 2'b01;
            else if (nib > 9)          code = 2'b10;
            else if (i == 2 && nib > 5) code = 2'b11;
            if (code != 2'b00 && !r.err) begin
                r.err  = 1'b1;
                r.code = code;
                r.edig = 3'(i);
            end
            d[i] = nib;
            r.digits[27 - 4*i -: 4] = 4'(nib);
            if (by[0] != ((i == 1) || (i == 3))) r.dp = 1'b1;
        end
        r.valid = !r.err;
        r.ms = r.valid ? 32'((d[0]*10 + d[1]) * 60000 + (d[2]*10 + d[3]) * 1000
                             + d[4]*100 + d[5]*10 + d[6]) : prev;
        return r;
    endfunction

    task automatic set_bytes(input logic [55:0] b);
        {bus.min_zehner, bus.min_einer, bus.sek_zehner, bus.sek_einer,
         bus.sek_zehntel, bus.sek_hundertstel, bus.sek_tausendstel} = b;
    endtask

    task automatic chk_outs(input string tag, input res_t e);
        chk({tag, ".digits"},    32'(bus.digits),    32'(e.digits));
        chk({tag, ".ms_count"},  bus.ms_count,       e.ms);
        chk({tag, ".valid"},     32'(bus.valid),     32'(e.valid));
        chk({tag, ".error"},     32'(bus.error),     32'(e.err));
        chk({tag, ".err_code"},  32'(bus.err_code),  32'(e.code));
        chk({tag, ".err_digit"}, 32'(bus.err_digit), 32'(e.edig));
        chk({tag, ".dp_fault"},  32'(bus.dp_fault),  32'(e.dp));
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".busy"}, 32'(bus.busy), 0);
        chk({tag, ".done"}, 32'(bus.done), 0);
        chk_outs(tag, '0);
    endtask

    task automatic do_decode(input string tag, input logic [55:0] b, input bit pulse, input res_t e);
        int lat;
        int extra;
        @(negedge clk);
        set_bytes(b);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        chk({tag, ".busy_start"}, 32'(bus.busy), 1);
        set_bytes({$urandom, $urandom});
        lat = 0;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk);
            #1;
            if (pulse && n == 2) bus.start = 1'b1;
            if (n == 5) bus.start = 1'b0;
            if (bus.done) begin lat = n; break; end
        end
        bus.start = 1'b0;
        chk({tag, ".latency"}, 32'(lat), 8);
        chk_outs(tag, e);
        chk({tag, ".busy_end"}, 32'(bus.busy), 0);
        @(posedge clk);
        #1;
        chk({tag, ".done_fall"}, 32'(bus.done), 0);
        if (pulse) begin
            extra = 0;
            for (int n = 0; n < 12; n++) begin
                @(posedge clk);
                #1;
                if (bus.done) extra++;
            end
            chk({tag, ".extra_done"}, 32'(extra), 0);
        end
        prev_ms = e.ms;
    endtask

    function automatic vec_t mk(input logic [55:0] b, input bit pulse, input logic [27:0] dg,
                                input logic [31:0] ms, input logic err, input logic [1:0] code,
                                input logic [2:0] edig, input logic dp);
        vec_t v;
        v.bytes = b;
        v.pulse = pulse;
        v.exp   = '{digits: dg, ms: ms, valid: !err, err: err, code: code, edig: edig, dp: dp};
        return v;
    endfunction

    vec_t tbl [5];

    initial begin
        tbl[0] = mk(56'hF7F7B6F7F6F6F6, 0, 28'h9959999, 32'd5999999, 0, 2'b00, 3'd0, 1);
        tbl[1] = mk(56'hFC61DAF366B6BE, 0, 28'h0123456, 32'd83456,   0, 2'b00, 3'd0, 0);
        tbl[2] = mk(56'hFC61BEF366B6BE, 0, 28'h0163456, 32'd83456,   1, 2'b11, 3'd2, 0);
        tbl[3] = mk(56'h0061DAF3EEB6BE, 0, 28'hF123A56, 32'd83456,   1, 2'b01, 3'd0, 0);
        tbl[4] = mk(56'hFC60DAF366B6BE, 1, 28'h0123456, 32'd83456,   0, 2'b00, 3'd0, 1);

        rst_n = 1'b0;
        bus.start = 1'b0;
        set_bytes('0);
        repeat (2) @(posedge clk);
        #1;
        chk_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++)
            do_decode($sformatf("vec%0d", i), tbl[i].bytes, tbl[i].pulse, tbl[i].exp);

        // Abort a decode with an asynchronous reset between clock edges.
        @(negedge clk);
        set_bytes(tbl[1].bytes);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero("midreset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        prev_ms = '0;
        begin
            int seen = 0;
            for (int n = 0; n < 12; n++) begin
                @(posedge clk);
                #1;
                if (bus.done) seen++;
            end
            chk("midreset.no_done", 32'(seen), 0);
        end
        do_decode("after_reset", tbl[1].bytes, 0, tbl[1].exp);

        for (int t = 0; t < 40; t++) begin
            logic [55:0] b;
            res_t e;
            for (int i = 0; i < 7; i++) begin
                logic [7:0] by;
                int sel;
                sel = int'($urandom_range(7));
                if (sel == 0)      by = 8'($urandom);
                else if (sel == 1) by = {pats[$urandom_range(15, 10)], 1'b0};
                else               by = {pats[$urandom_range(9)], 1'b0};
                by[0] = (i == 1) || (i == 3);
                if ($urandom_range(3) == 0) by[0] = ~by[0];
                b[55 - 8*i -: 8] = by;
            end
            e = model(b, prev_ms);
            do_decode($sformatf("rand%0d", t), b, 0, e);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
